// File: rtl/time_display_mux.sv
// time_display_mux
//   Drives a 6-digit multiplexed 7-segment display (HH.MM.SS) from the
//   binary hour/min/sec outputs of the clock core. The time is captured
//   once per scan frame, so a rollover in the middle of a frame cannot
//   tear the displayed value.
//
// Parameters
//   SCAN_DIV       clk cycles each digit stays lit (2..2^20)
//   SEG_ACTIVE_LOW 1: seg/dp driven low = lit
//   AN_ACTIVE_LOW  1: an driven low = digit selected
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   hour  in   [4:0] binary hours (0..31)
//   min   in   [5:0] binary minutes (0..63)
//   sec   in   [5:0] binary seconds (0..63)
//   seg   out  [6:0] segments {g,f,e,d,c,b,a}
//   dp    out  decimal point (lit on the separator digits 2 and 4)
//   an    out  [5:0] digit enables, bit0 = rightmost digit
//
// Optional build macro
//   HOUR_LEADING_ZERO_BLANK_EN  blanks the hour-tens digit when hour < 10;
//                               the digit slot is still scanned so the
//                               frame timing does not change.
module time_display_mux #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    // Inactive levels double as XOR masks converting active-high to pin polarity.
    localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [5:0]     AN_OFF   = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

    // Active-high segment pattern (bit0 = a) for a decimal digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Tens digit of a 0..63 value (no clamping; 60..63 gives 6).
    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    // Ones digit of a 0..63 value.
    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [4:0]    hour_snap_r;
    logic [5:0]    min_snap_r;
    logic [5:0]    sec_snap_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [5:0]    an_r;

    logic [3:0]    digit_s;
    logic          blank_s;
    logic [6:0]    seg_act_s;
    logic          dp_act_s;
    logic [5:0]    an_act_s;

    // Dwell counter, digit index and per-frame time snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            hour_snap_r <= 5'd0;
            min_snap_r  <= 6'd0;
            sec_snap_r  <= 6'd0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= CNT_ZERO;
                if (idx_r == 3'd5) begin
                    idx_r <= 3'd0;
                end else begin
                    idx_r <= idx_r + 3'd1;
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            // Frame start: the only point where the inputs are looked at.
            if ((cnt_r == CNT_ZERO) && (idx_r == 3'd0)) begin
                hour_snap_r <= hour;
                min_snap_r  <= min;
                sec_snap_r  <= sec;
            end else begin
                hour_snap_r <= hour_snap_r;
                min_snap_r  <= min_snap_r;
                sec_snap_r  <= sec_snap_r;
            end
        end
    end

    // Select the digit for the current index and build active-high outputs.
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            3'd0:    digit_s = bcd_ones(sec_snap_r);
            3'd1:    digit_s = bcd_tens(sec_snap_r);
            3'd2:    digit_s = bcd_ones(min_snap_r);
            3'd3:    digit_s = bcd_tens(min_snap_r);
            3'd4:    digit_s = bcd_ones({1'b0, hour_snap_r});
            3'd5:    digit_s = bcd_tens({1'b0, hour_snap_r});
            default: digit_s = 4'd0;
        endcase

`ifdef HOUR_LEADING_ZERO_BLANK_EN
        blank_s = (idx_r == 3'd5) && (hour_snap_r < 5'd10);
`else
        blank_s = 1'b0;
`endif

        if (blank_s) begin
            seg_act_s = 7'h00;
            dp_act_s  = 1'b0;
        end else begin
            seg_act_s = seg_encode(digit_s);
            dp_act_s  = (idx_r == 3'd2) || (idx_r == 3'd4);
        end
        // The blanked digit keeps its enable so scan timing is unchanged.
        an_act_s = 6'b000001 << idx_r;
    end

    // Registered pin outputs; one cycle behind the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_OFF;
            dp_r  <= DP_OFF;
            an_r  <= AN_OFF;
        end else begin
            seg_r <= seg_act_s ^ SEG_OFF;
            dp_r  <= dp_act_s ^ DP_OFF;
            an_r  <= an_act_s ^ AN_OFF;
        end
    end

    assign seg = seg_r;
    assign dp  = dp_r;
    assign an  = an_r;

endmodule

// File: tb/tb_time_display_mux.sv
module tb_time_display_mux;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] hour_s;
    logic [5:0] min_s;
    logic [5:0] sec_s;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int tests = 0;
    int fails = 0;

    // Bench-side view of the display state: edges since reset release and
    // the time the display should currently be showing.
    int         k;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [5:0] ss;
    exp_t       sb_q[$];

    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [35:0] lit_an = {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};

    time_display_mux #(
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .hour (hour_s),
        .min  (min_s),
        .sec  (sec_s),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t       e;
        int         d;
        int         v;
        logic [6:0] hi;
        d = (k / 4) % 6;
        case (d)
            0:       v = ss % 10;
            1:       v = ss / 10;
            2:       v = sm % 10;
            3:       v = sm / 10;
            4:       v = sh % 10;
            default: v = sh / 10;
        endcase
        hi = tbl[v];
`ifdef HOUR_LEADING_ZERO_BLANK_EN
        if (d == 5 && sh < 5'd10) hi = 7'h00;
`endif
        e.seg = ~hi;
        e.an  = ~(6'b000001 << d);
        e.dp  = !(d == 2 || d == 4);
        return e;
    endfunction

    // One clock: predict, advance the bench view, clock, compare.
    task automatic step();
        exp_t e;
        sb_q.push_back(model_out());
        if (k % 24 == 0) begin
            sh = hour_s;
            sm = min_s;
            ss = sec_s;
        end
        k++;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("an", {26'd0, an}, {26'd0, e.an});
        chk("seg", {25'd0, seg}, {25'd0, e.seg});
        chk("dp", {31'd0, dp}, {31'd0, e.dp});
        chk("onehot", $countones(~an), 1);
    endtask

    task automatic rst_cycles(input int n);
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{an: 6'h3F, seg: 7'h7F, dp: 1'b1});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk("rst_an", {26'd0, an}, {26'd0, e.an});
            chk("rst_seg", {25'd0, seg}, {25'd0, e.seg});
            chk("rst_dp", {31'd0, dp}, {31'd0, e.dp});
        end
        rst = 1'b0;
        k  = 0;
        sh = 5'd0;
        sm = 6'd0;
        ss = 6'd0;
    endtask

    task automatic run_to_frame_start();
        while (k % 24 != 0) step();
    endtask

    // Full frame with literal per-digit segment values {d5..d0}.
    task automatic run_frame_lit(input string tag, input logic [41:0] segs);
        for (int c = 0; c < 24; c++) begin
            step();
            chk({tag, "_an"}, {26'd0, an}, {26'd0, lit_an[6*(c/4) +: 6]});
            if (c > 0) chk({tag, "_seg"}, {25'd0, seg}, {25'd0, segs[7*(c/4) +: 7]});
        end
    endtask

    initial begin
        logic [5:0] prev_an;
        int         run_len;
        bit         run_ok;
        logic [6:0] h_tens;

        rst    = 1'b1;
        hour_s = 5'd12;
        min_s  = 6'd34;
        sec_s  = 6'd56;
        k      = 0;
        sh     = 5'd0;
        sm     = 6'd0;
        ss     = 6'd0;

        // Reset and first edges after release.
        rst_cycles(3);
        step();
        chk("edge0_an", {26'd0, an}, 32'h3E);
        chk("edge0_seg", {25'd0, seg}, 32'h40);
        step();
        chk("edge1_seg", {25'd0, seg}, 32'h02);
        while (k < 24) step();

        // Steady 12:34:56 frame.
        run_frame_lit("f123456", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        // Coherency: 34:59 captured, time moves to 35:00 while digit 3 is lit.
        sec_s = 6'd59;
        run_to_frame_start();
        while (k % 24 != 13) step();
        chk("coh_an", {26'd0, an}, 32'h37);
        chk("coh_seg", {25'd0, seg}, 32'h30);
        min_s = 6'd35;
        sec_s = 6'd0;
        run_to_frame_start();
        step();
        chk("coh_old_sec", {25'd0, seg}, 32'h10);
        for (int c = 1; c < 24; c++) step();
        run_frame_lit("f123500", {7'h79, 7'h24, 7'h30, 7'h12, 7'h40, 7'h40});

        // 05:07:63 - hour tens zero (or blank) and literal "63".
        hour_s = 5'd5;
        min_s  = 6'd7;
        sec_s  = 6'd63;
        run_to_frame_start();
        step();
        for (int c = 1; c < 24; c++) step();
`ifdef HOUR_LEADING_ZERO_BLANK_EN
        h_tens = 7'h7F;
`else
        h_tens = 7'h40;
`endif
        run_frame_lit("f050763", {h_tens, 7'h12, 7'h40, 7'h78, 7'h02, 7'h30});

        // Mid-frame reset while digit 3 is lit, then restart with a new time.
        while (k % 24 != 13) step();
        chk("pre_rst_an", {26'd0, an}, 32'h37);
        hour_s = 5'd8;
        min_s  = 6'd9;
        sec_s  = 6'd10;
        rst_cycles(1);
        step();
        chk("restart_an", {26'd0, an}, 32'h3E);
        step();
        chk("restart_seg", {25'd0, seg}, 32'h40);
        for (int c = 2; c < 24; c++) step();
        run_frame_lit("f080910", {7'h40, 7'h00, 7'h40, 7'h10, 7'h79, 7'h40});

        // Long run with input changes and dwell-length tracking.
        run_to_frame_start();
        prev_an = an;
        run_len = 0;
        run_ok  = 1'b0;
        for (int i = 0; i < 240; i++) begin
            if (i % 17 == 5) begin
                hour_s = 5'($urandom_range(0, 31));
                min_s  = 6'($urandom_range(0, 63));
                sec_s  = 6'($urandom_range(0, 63));
            end
            step();
            if (an != prev_an) begin
                if (run_ok) chk("dwell", run_len, 4);
                run_len = 1;
                run_ok  = 1'b1;
                prev_an = an;
            end else begin
                run_len++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
